layer_compositor: RTL and testbench
===================================

# layer_compositor

Parametrised N-layer pixel compositor for the VGA path. It selects the visible RGB per pixel from a runtime-programmable priority table instead of a hard-wired if/else chain, and holds per-layer enables. Table and enables are written through a shadow/commit scheme, so changes only take effect at frame boundaries. It optionally reports per-frame layer overlap (collision) to game logic. It sits between the object drawers and the VGA controller, replacing the fixed priority mux.

## Interface
- NUM_LAYERS, 8, number of drawable layers (2..16)
- RGB_W, 8, pixel colour width
- IDX_W, $clog2(NUM_LAYERS), layer/slot index width
- Reset: resetN, asynchronous, active-low. Clock: clk.
- clk  in  1  pixel clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse, coincident with the first pixel of a frame
- layerDR  in  NUM_LAYERS  per-layer draw request; bit i belongs to layer i
- layerRGB  in  NUM_LAYERS*RGB_W  layer i colour in bits [i*RGB_W +: RGB_W]
- bgRGB  in  RGB_W  background colour, used when no layer wins
- cfgWr  in  1  priority-table write strobe
- cfgSlot  in  IDX_W  slot to write; 0 is highest priority
- cfgLayer  in  IDX_W  layer index stored into the slot
- cfgMaskWr  in  1  enable-mask write strobe
- cfgMask  in  NUM_LAYERS  new layer-enable mask
- cfgPending  out  1  shadow holds uncommitted writes
- RGBOut  out  RGB_W  composited pixel
- topLayer  out  IDX_W  index of the winning layer
- topValid  out  1  a layer won; 0 means the background is shown
- collisionVec  out  NUM_LAYERS  layers that overlapped during the previous frame
- collisionIrq  out  1  one-cycle pulse when a nonzero collisionVec is published

## Operation
- Active and shadow copies exist for the priority table (NUM_LAYERS slots × IDX_W) and for the enable mask.
- Reset value of both copies: slot p = layer p (identity order); mask = all ones.
- cfgWr writes shadow[cfgSlot] = cfgLayer. A cfgSlot ≥ NUM_LAYERS is ignored and does not set cfgPending.
- cfgMaskWr writes the shadow mask. cfgWr and cfgMaskWr in the same cycle both take effect.
- Commit happens on a startOfFrame cycle: active ← shadow, and cfgPending clears.
- The pixel sampled in the startOfFrame cycle already uses the committed values, through a combinational bypass.
- A write in the same cycle as startOfFrame lands in shadow only. It is not committed by that edge, and cfgPending ends that cycle at 1.
- Stage 1 registers the following:
  - drawEff = layerDR & effective mask;
  - all layerRGB;
  - bgRGB;
  - the effective table;
  - startOfFrame.
- Stage 2 scans slots 0..NUM_LAYERS-1. The first slot whose layer has drawEff set wins.
  - Winner found: RGBOut = that layer's RGB, topLayer = its index, topValid = 1.
  - No winner: RGBOut = bgRGB, topLayer = 0, topValid = 0.
- Layers missing from the table never win, but still count toward collisions.
- A layer listed in several slots wins at its highest-priority slot.
- Collision, evaluated at stage 2:
  - If popcount(drawEff) ≥ 2, OR drawEff into the accumulator.
  - When the delayed startOfFrame reaches stage 2: collisionVec ← accumulator, then the accumulator ← that pixel's own contribution.
  - collisionIrq = 1 for that one cycle iff the accumulator value being published is nonzero.
- Reset values: RGBOut=0, topLayer=0, topValid=0, cfgPending=0, collisionVec=0, collisionIrq=0; accumulator and pipeline registers are 0.
- A reset mid-frame returns the tables to identity order and the mask to all ones, and discards pending writes and the accumulator.

## Timing
- Latency is fixed at 2 cycles: inputs sampled at edge N appear on RGBOut, topLayer and topValid after edge N+1. Throughput is one pixel per cycle with no stalls.
- cfgPending rises on the edge after an accepted write and falls on the edge that samples startOfFrame.
- collisionVec and collisionIrq update 2 cycles after startOfFrame, aligned with the first pixel of the new frame on RGBOut.
- Back-to-back startOfFrame pulses (1-cycle frames) are legal. Each pulse publishes exactly that single pixel's contribution.

## Configuration
- COMPOSITOR_COLLISION_EN defined: the collision accumulator, collisionVec and collisionIrq are implemented as described above.
- Not defined: the accumulator is not built, collisionVec is tied to 0 and collisionIrq to 0. Compositing and configuration are unchanged.

## Test plan
- Reset state, NUM_LAYERS=8: layerDR=8'b0000_0110, layer1 RGB=0x1C, layer2 RGB=0xE0 → RGBOut=0x1C, topLayer=1 after 2 cycles.
- Reorder: write slot0=2 and slot2=0, then pulse startOfFrame with the same pixel as above → that pixel outputs 0xE0 with topLayer=2. Before the pulse the output stays 0x1C and cfgPending=1.
- Mask: write cfgMask=8'hFB, then commit → layer2 is suppressed, and layerDR=8'h04 outputs bgRGB=0x25 with topValid=0.
- Write coinciding with startOfFrame: the old shadow is committed, cfgPending=1 afterwards, and the new value applies at the next startOfFrame.
- Collision (macro defined): layers 3 and 5 overlap at one pixel in a frame → at the next startOfFrame+2, collisionVec=8'h28 and collisionIrq pulses for exactly 1 cycle. A frame with no overlap publishes 0 with no pulse.
- Reset asserted mid-frame after config writes → all outputs return to 0, identity order is restored, and cfgPending=0.

Source files
------------

// File: rtl/layer_compositor_if.sv
// Configuration bus of layer_compositor: priority-table writes, enable-mask
// writes and the pending-commit status flag.
interface layer_compositor_if #(
   parameter int NUM_LAYERS = 8,
   parameter int IDX_W      = $clog2(NUM_LAYERS)
) ();
   logic                  cfgWr;
   logic [IDX_W-1:0]      cfgSlot;
   logic [IDX_W-1:0]      cfgLayer;
   logic                  cfgMaskWr;
   logic [NUM_LAYERS-1:0] cfgMask;
   logic                  cfgPending;

   modport master (
      output cfgWr, cfgSlot, cfgLayer, cfgMaskWr, cfgMask,
      input  cfgPending
   );

   modport slave (
      input  cfgWr, cfgSlot, cfgLayer, cfgMaskWr, cfgMask,
      output cfgPending
   );
endinterface

// File: rtl/layer_compositor.sv
// N-layer pixel compositor with frame-synchronous shadow/commit priority table and enables.
// Optional per-frame collision reporting is built when COMPOSITOR_COLLISION_EN is defined.
module layer_compositor #(
   parameter int NUM_LAYERS = 8,
   parameter int RGB_W      = 8,
   parameter int IDX_W      = $clog2(NUM_LAYERS)
) (
   input  logic                        clk,
   input  logic                        resetN,
   input  logic                        startOfFrame,
   input  logic [NUM_LAYERS-1:0]       layerDR,
   input  logic [NUM_LAYERS*RGB_W-1:0] layerRGB,
   input  logic [RGB_W-1:0]            bgRGB,
   layer_compositor_if.slave           cfg,
   output logic [RGB_W-1:0]            RGBOut,
   output logic [IDX_W-1:0]            topLayer,
   output logic                        topValid,
   output logic [NUM_LAYERS-1:0]       collisionVec,
   output logic                        collisionIrq
);

   logic [IDX_W-1:0]      shadow_tab [NUM_LAYERS];
   logic [IDX_W-1:0]      active_tab [NUM_LAYERS];
   logic [IDX_W-1:0]      eff_tab    [NUM_LAYERS];
   logic [IDX_W-1:0]      s1_tab     [NUM_LAYERS];
   logic [NUM_LAYERS-1:0] shadow_mask;
   logic [NUM_LAYERS-1:0] active_mask;
   logic [NUM_LAYERS-1:0] eff_mask;
   logic                  pending;
   logic                  slot_wr;

   logic [NUM_LAYERS-1:0]       s1_draw;
   logic [NUM_LAYERS*RGB_W-1:0] s1_rgb;
   logic [RGB_W-1:0]            s1_bg;

   logic                  win_found;
   logic [IDX_W-1:0]      win_layer;
   logic [RGB_W-1:0]      win_rgb;

   assign slot_wr        = cfg.cfgWr && (int'(cfg.cfgSlot) < NUM_LAYERS);
   assign cfg.cfgPending = pending;

   // The startOfFrame pixel already sees the shadow contents it is about to commit.
   always_comb begin
      for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
         eff_tab[i] = startOfFrame ? shadow_tab[i] : active_tab[i];
      end
      eff_mask = startOfFrame ? shadow_mask : active_mask;
   end

   // Slot 0 is scanned first; a layer index beyond NUM_LAYERS can never win.
   always_comb begin
      win_found = 1'b0;
      win_layer = '0;
      for (int unsigned p = 0; p < NUM_LAYERS; p++) begin
         if (!win_found && (int'(s1_tab[p]) < NUM_LAYERS) && s1_draw[s1_tab[p]]) begin
            win_found = 1'b1;
            win_layer = s1_tab[p];
         end
      end
      win_rgb = s1_rgb[int'(win_layer)*RGB_W +: RGB_W];
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            shadow_tab[i] <= IDX_W'(i);
            active_tab[i] <= IDX_W'(i);
            s1_tab[i]     <= '0;
         end
         shadow_mask <= '1;
         active_mask <= '1;
         pending     <= 1'b0;
         s1_draw     <= '0;
         s1_rgb      <= '0;
         s1_bg       <= '0;
         RGBOut      <= '0;
         topLayer    <= '0;
         topValid    <= 1'b0;
      end else begin
         if (startOfFrame) begin
            active_tab  <= shadow_tab;
            active_mask <= shadow_mask;
         end
         if (slot_wr) begin
            shadow_tab[cfg.cfgSlot] <= cfg.cfgLayer;
         end
         if (cfg.cfgMaskWr) begin
            shadow_mask <= cfg.cfgMask;
         end
         // A write coinciding with the commit edge stays pending for the next frame.
         if (slot_wr || cfg.cfgMaskWr) begin
            pending <= 1'b1;
         end else if (startOfFrame) begin
            pending <= 1'b0;
         end

         s1_draw <= layerDR & eff_mask;
         s1_rgb  <= layerRGB;
         s1_bg   <= bgRGB;
         s1_tab  <= eff_tab;

         RGBOut   <= win_found ? win_rgb : s1_bg;
         topLayer <= win_layer;
         topValid <= win_found;
      end
   end

`ifdef COMPOSITOR_COLLISION_EN
   logic                  s1_sof;
   logic [NUM_LAYERS-1:0] acc;
   logic [NUM_LAYERS-1:0] contrib;

   assign contrib = ($countones(s1_draw) >= 2) ? s1_draw : '0;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         s1_sof       <= 1'b0;
         acc          <= '0;
         collisionVec <= '0;
         collisionIrq <= 1'b0;
      end else begin
         s1_sof <= startOfFrame;
         if (s1_sof) begin
            collisionVec <= acc;
            collisionIrq <= |acc;
            acc          <= contrib;
         end else begin
            collisionIrq <= 1'b0;
            acc          <= acc | contrib;
         end
      end
   end
`else
   assign collisionVec = '0;
   assign collisionIrq = 1'b0;
`endif

endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench for layer_compositor: directed vector table, collision and reset
// sequences, and randomized traffic against a per-pixel reference model.
module tb_layer_compositor;

`ifdef COMPOSITOR_COLLISION_EN
   localparam bit COLL = 1'b1;
`else
   localparam bit COLL = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        resetN;
   logic        startOfFrame;
   logic [7:0]  layerDR;
   logic [63:0] layerRGB;
   logic [7:0]  bgRGB;
   logic [7:0]  RGBOut;
   logic [2:0]  topLayer;
   logic        topValid;
   logic [7:0]  collisionVec;
   logic        collisionIrq;

   layer_compositor_if #(.NUM_LAYERS(8), .IDX_W(3)) cif ();

   layer_compositor #(.NUM_LAYERS(8), .RGB_W(8), .IDX_W(3)) dut (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .layerDR      (layerDR),
      .layerRGB     (layerRGB),
      .bgRGB        (bgRGB),
      .cfg          (cif),
      .RGBOut       (RGBOut),
      .topLayer     (topLayer),
      .topValid     (topValid),
      .collisionVec (collisionVec),
      .collisionIrq (collisionIrq)
   );

   always #5 clk = ~clk;

   // layer7..layer0 colours
   localparam logic [63:0] PAL = 64'h8574_6352_41E0_1C03;
   localparam logic [7:0]  BG  = 8'h25;

   typedef struct {
      logic [7:0] rgb;
      logic [2:0] top;
      logic       valid;
      logic [7:0] cvec;
      logic       irq;
   } px_t;

   typedef struct {
      bit         sof;
      bit         wr;
      logic [2:0] slot;
      logic [2:0] lay;
      bit         mwr;
      logic [7:0] mask;
      logic [7:0] dr;
      logic [7:0] e_rgb;
      logic [2:0] e_top;
      bit         e_valid;
      bit         e_pend;
   } vec_t;

   int n_pass  = 0;
   int n_total = 0;

   logic [2:0] m_sh_tab  [8];
   logic [2:0] m_act_tab [8];
   logic [7:0] m_sh_mask, m_act_mask;
   logic       m_pending;
   logic [7:0] m_frame_acc, m_cvec;
   px_t        prev;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_sh_tab[i]  = 3'(i);
         m_act_tab[i] = 3'(i);
      end
      m_sh_mask   = 8'hFF;
      m_act_mask  = 8'hFF;
      m_pending   = 1'b0;
      m_frame_acc = 8'h00;
      m_cvec      = 8'h00;
      prev        = '{rgb: 8'h00, top: 3'd0, valid: 1'b0, cvec: 8'h00, irq: 1'b0};
   endtask

   // Drives one pixel, advances one clock and checks the pixel from the previous call.
   task automatic step(input bit sof, input logic [7:0] dr, input logic [63:0] rgbs,
                       input logic [7:0] bg, input bit wr, input logic [2:0] slot,
                       input logic [2:0] lay, input bit mwr, input logic [7:0] mask);
      logic [2:0] tab [8];
      logic [7:0] msk, vis, contrib;
      px_t        cur;
      startOfFrame  = sof;
      layerDR       = dr;
      layerRGB      = rgbs;
      bgRGB         = bg;
      cif.cfgWr     = wr;
      cif.cfgSlot   = slot;
      cif.cfgLayer  = lay;
      cif.cfgMaskWr = mwr;
      cif.cfgMask   = mask;

      for (int i = 0; i < 8; i++) tab[i] = sof ? m_sh_tab[i] : m_act_tab[i];
      msk = sof ? m_sh_mask : m_act_mask;
      vis = dr & msk;
      cur = '{rgb: bg, top: 3'd0, valid: 1'b0, cvec: 8'h00, irq: 1'b0};
      for (int p = 0; p < 8; p++) begin
         if (!cur.valid && vis[tab[p]]) begin
            cur.valid = 1'b1;
            cur.top   = tab[p];
            cur.rgb   = rgbs[int'(tab[p])*8 +: 8];
         end
      end
      contrib = ($countones(vis) >= 2) ? vis : 8'h00;
      if (sof) begin
         m_cvec      = m_frame_acc;
         cur.irq     = (m_frame_acc != 8'h00);
         m_frame_acc = contrib;
      end else begin
         m_frame_acc = m_frame_acc | contrib;
      end
      cur.cvec = m_cvec;
      if (!COLL) begin
         cur.cvec = 8'h00;
         cur.irq  = 1'b0;
      end

      if (sof) begin
         m_act_tab  = m_sh_tab;
         m_act_mask = m_sh_mask;
         m_pending  = 1'b0;
      end
      if (wr) begin
         m_sh_tab[slot] = lay;
         m_pending      = 1'b1;
      end
      if (mwr) begin
         m_sh_mask = mask;
         m_pending = 1'b1;
      end

      @(posedge clk);
      #1;
      check("model_rgb",     32'(RGBOut),       32'(prev.rgb));
      check("model_top",     32'(topLayer),     32'(prev.top));
      check("model_valid",   32'(topValid),     32'(prev.valid));
      check("model_cvec",    32'(collisionVec), 32'(prev.cvec));
      check("model_irq",     32'(collisionIrq), 32'(prev.irq));
      check("model_pending", 32'(cif.cfgPending), 32'(m_pending));
      prev = cur;
   endtask

   task automatic idle(input bit sof, input logic [7:0] dr);
      step(sof, dr, PAL, BG, 1'b0, 3'd0, 3'd0, 1'b0, 8'h00);
   endtask

   task automatic check_pixel(input string name, input logic [7:0] rgb, input logic [2:0] top, input bit valid);
      check({name, "_rgb"},   32'(RGBOut),   32'(rgb));
      check({name, "_top"},   32'(topLayer), 32'(top));
      check({name, "_valid"}, 32'(topValid), 32'(valid));
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl [16];

      tbl[0]  = '{0, 0, 3'd0, 3'd0, 0, 8'h00, 8'h06, 8'h1C, 3'd1, 1, 0};
      tbl[1]  = '{0, 1, 3'd0, 3'd2, 0, 8'h00, 8'h06, 8'h1C, 3'd1, 1, 1};
      tbl[2]  = '{0, 1, 3'd2, 3'd0, 0, 8'h00, 8'h06, 8'h1C, 3'd1, 1, 1};
      tbl[3]  = '{0, 0, 3'd0, 3'd0, 0, 8'h00, 8'h06, 8'h1C, 3'd1, 1, 1};
      tbl[4]  = '{1, 0, 3'd0, 3'd0, 0, 8'h00, 8'h06, 8'hE0, 3'd2, 1, 0};
      tbl[5]  = '{0, 0, 3'd0, 3'd0, 0, 8'h00, 8'h06, 8'hE0, 3'd2, 1, 0};
      tbl[6]  = '{0, 0, 3'd0, 3'd0, 1, 8'hFB, 8'h04, 8'hE0, 3'd2, 1, 1};
      tbl[7]  = '{1, 0, 3'd0, 3'd0, 0, 8'h00, 8'h04, 8'h25, 3'd0, 0, 0};
      tbl[8]  = '{0, 0, 3'd0, 3'd0, 0, 8'h00, 8'h06, 8'h1C, 3'd1, 1, 0};
      tbl[9]  = '{1, 0, 3'd0, 3'd0, 1, 8'hFF, 8'h04, 8'h25, 3'd0, 0, 1};
      tbl[10] = '{0, 0, 3'd0, 3'd0, 0, 8'h00, 8'h04, 8'h25, 3'd0, 0, 1};
      tbl[11] = '{1, 0, 3'd0, 3'd0, 0, 8'h00, 8'h04, 8'hE0, 3'd2, 1, 0};
      tbl[12] = '{0, 0, 3'd0, 3'd0, 0, 8'h00, 8'h00, 8'h25, 3'd0, 0, 0};
      tbl[13] = '{0, 1, 3'd0, 3'd7, 0, 8'h00, 8'h81, 8'h03, 3'd0, 1, 1};
      tbl[14] = '{1, 0, 3'd0, 3'd0, 0, 8'h00, 8'h81, 8'h85, 3'd7, 1, 0};
      tbl[15] = '{0, 0, 3'd0, 3'd0, 0, 8'h00, 8'h04, 8'h25, 3'd0, 0, 0};

      resetN        = 1'b0;
      startOfFrame  = 1'b0;
      layerDR       = 8'h00;
      layerRGB      = 64'h0;
      bgRGB         = 8'h00;
      cif.cfgWr     = 1'b0;
      cif.cfgSlot   = 3'd0;
      cif.cfgLayer  = 3'd0;
      cif.cfgMaskWr = 1'b0;
      cif.cfgMask   = 8'h00;
      model_reset();

      repeat (2) @(posedge clk);
      #1;
      check_pixel("reset", 8'h00, 3'd0, 1'b0);
      check("reset_pending", 32'(cif.cfgPending), 32'd0);
      check("reset_cvec",    32'(collisionVec),   32'd0);
      check("reset_irq",     32'(collisionIrq),   32'd0);
      @(negedge clk);
      resetN = 1'b1;

      for (int k = 0; k < 16; k++) begin
         step(tbl[k].sof, tbl[k].dr, PAL, BG, tbl[k].wr, tbl[k].slot, tbl[k].lay, tbl[k].mwr, tbl[k].mask);
         check($sformatf("vec%0d_pending", k), 32'(cif.cfgPending), 32'(tbl[k].e_pend));
         if (k > 0) check_pixel($sformatf("vec%0d", k - 1), tbl[k-1].e_rgb, tbl[k-1].e_top, tbl[k-1].e_valid);
      end
      idle(1'b0, 8'h00);
      check_pixel("vec15", tbl[15].e_rgb, tbl[15].e_top, tbl[15].e_valid);

      // Frame with layers 3 and 5 overlapping once.
      idle(1'b1, 8'h00);
      idle(1'b0, 8'h28);
      idle(1'b0, 8'h08);
      idle(1'b1, 8'h00);
      idle(1'b0, 8'h00);
      check("coll_vec",     32'(collisionVec), COLL ? 32'h28 : 32'h0);
      check("coll_irq",     32'(collisionIrq), COLL ? 32'd1  : 32'd0);
      idle(1'b0, 8'h08);
      check("coll_irq_end", 32'(collisionIrq), 32'd0);
      check("coll_vec_hold", 32'(collisionVec), COLL ? 32'h28 : 32'h0);
      idle(1'b0, 8'h20);
      idle(1'b1, 8'h00);
      idle(1'b0, 8'h00);
      check("nocoll_vec", 32'(collisionVec), 32'h0);
      check("nocoll_irq", 32'(collisionIrq), 32'd0);

      // Back-to-back one-pixel frames.
      idle(1'b1, 8'h03);
      idle(1'b1, 8'h00);
      idle(1'b1, 8'h00);
      check("b2b_vec",  32'(collisionVec), COLL ? 32'h03 : 32'h0);
      check("b2b_irq",  32'(collisionIrq), COLL ? 32'd1  : 32'd0);
      idle(1'b0, 8'h00);
      check("b2b_vec2", 32'(collisionVec), 32'h0);
      check("b2b_irq2", 32'(collisionIrq), 32'd0);

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 7) == 0), 8'($urandom), {$urandom, $urandom}, 8'($urandom),
              ($urandom_range(0, 3) == 0), 3'($urandom), 3'($urandom),
              ($urandom_range(0, 7) == 0), 8'($urandom));
      end

      // Reset asserted mid-frame after config writes.
      step(1'b0, 8'h06, PAL, BG, 1'b1, 3'd0, 3'd5, 1'b0, 8'h00);
      step(1'b0, 8'h3C, PAL, BG, 1'b0, 3'd0, 3'd0, 1'b1, 8'h0F);
      #2;
      resetN = 1'b0;
      #1;
      check_pixel("midrst", 8'h00, 3'd0, 1'b0);
      check("midrst_pending", 32'(cif.cfgPending), 32'd0);
      check("midrst_cvec",    32'(collisionVec),   32'd0);
      check("midrst_irq",     32'(collisionIrq),   32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetN = 1'b1;
      model_reset();
      idle(1'b1, 8'h06);
      idle(1'b0, 8'h06);
      check_pixel("postrst_sof", 8'h1C, 3'd1, 1'b1);
      idle(1'b0, 8'h00);
      check_pixel("postrst", 8'h1C, 3'd1, 1'b1);
      check("postrst_pending", 32'(cif.cfgPending), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
